// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word channel from a byte producer into uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with built-in bit timer and a small input FIFO.
// Frame: START, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    uart_tx_fifo_if.slave                   s,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);
    localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic push, pop, bit_end, frame_end, parity_bit;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        bit_end    = (cnt_q == CNT_LAST);
        frame_end  = (state_q == ST_STOP) && bit_end && (stop_q == STOP_LAST);
        push       = s.s_valid && ready_q;
        pop        = (count_q != '0) && ((state_q == ST_IDLE) || frame_end);
        parity_bit = (PARITY == 2) ? ~(^word_q) : (^word_q);

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + NW'(push) - NW'(pop);
        ready_d  = (count_d != COUNT_FULL);

        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        stop_d  = stop_q;
        word_d  = word_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    state_d = ST_START;
                    word_d  = mem_q[rd_ptr_q];
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        // Back-to-back frames reload here without passing through IDLE.
                        if (pop) begin
                            state_d = ST_START;
                            word_d  = mem_q[rd_ptr_q];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = word_q[bit_q];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            word_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            word_q   <= word_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s.s_data;
        end
    end

    assign s.s_ready  = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. Integrates its own bit-period counter, so no external baud tick or derived clock is needed. Adds compile-time data width, parity mode and stop-bit count, plus a small input FIFO behind a valid/ready handshake. Sits between a byte producer and the pad-level TX pin in the tt_um top level.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600); legal >= 2
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_data  input  DATA_BITS  word to send
s_valid  input  1  producer has word on s_data
s_ready  output  1  FIFO can accept; transfer when s_valid && s_ready at a clk edge
tx  output  1  serial line, idle high
busy  output  1  high while a frame is on the line
fifo_count  output  $clog2(FIFO_DEPTH+1)  words queued, excluding the frame in flight

Behaviour:
- One clock and one reset: clk; reset is synchronous and active-high (rst). All outputs registered.
- Reset values: tx=1, busy=0, fifo_count=0, s_ready=1; FIFO pointers cleared, bit counter cleared, state IDLE.
- Reset mid-frame: frame abandoned, tx=1 from the next edge, queued words discarded.
- s_ready = (fifo_count != FIFO_DEPTH), derived from the registered count. No push when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle: count unchanged. Pop only when count != 0 at that edge, so there is no write-through to an empty FIFO.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Frame format, LSB first: START(0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1).
  - Even parity = XOR of the data bits.
  - Odd parity = inverted XOR.
  - Frame length = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- Every bit holds tx for exactly CLKS_PER_BIT cycles. The bit counter is cleared on frame start and counts 0..CLKS_PER_BIT-1; the bit advances on the terminal count.
- States and transitions:
  - IDLE: tx=1, busy=0. If count != 0, pop the head into the shift register and go to START.
  - START: tx=0 → DATA.
  - DATA: bit index 0..DATA_BITS-1 → PARITY if PARITY != 0, else STOP.
  - PARITY: tx = computed parity → STOP.
  - STOP: tx=1; stop-bit index 0..STOP_BITS-1.
- End of the last stop bit:
  - If count != 0, pop and enter START on the same edge (back-to-back frames, no idle gap).
  - Else go to IDLE.
- Latency: word accepted at edge N into an empty FIFO while IDLE → popped at edge N+1 → tx=0 and busy=1 from edge N+2.
- busy = (state != IDLE). It stays high continuously across back-to-back frames.
- s_data is sampled only at acceptance. Later changes do not affect queued words.
- Illegal parameter values are rejected at elaboration with $error.

Test Plan:
1. CLKS_PER_BIT=4, 8N1 defaults otherwise; push 0xA5 → tx low at N+2 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1 for 4 cycles; busy high 40 cycles; fifo_count returns to 0.
2. PARITY=1, then PARITY=2, send 0xA5 → parity bit 0 (even) / 1 (odd) after bit 7; frame 44 cycles; STOP_BITS=2 → 48 cycles, tx high for the last 8.
3. FIFO_DEPTH=4; hold s_valid with 0x01..0x06 → 5 words accepted (1 popped + 4 queued), s_ready low with count=4; 5 frames emitted back-to-back with no idle cycle; s_ready reasserts after the next pop.
4. Push while full in the same cycle as a pop → push rejected (s_ready=0), count 4→3; push and pop together at count=2 → count stays 2.
5. Assert rst for 1 cycle mid-DATA of a 3-word burst → next edge tx=1, busy=0, fifo_count=0, s_ready=1; a new push afterwards sends a clean frame.
6. DATA_BITS=5, PARITY=0, send 0x1F → 1+5+1 bits = 7 bits; 0x3F input upper bits are irrelevant because the port is 5 bits wide.
